// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if
//   Handshake and result bundle between a producer of binary values and the
//   sequential binary-to-BCD converter.
//
//   Signals:
//     start    - request a conversion of bin_in (producer -> converter)
//     bin_in   - unsigned binary value, BIN_W bits (producer -> converter)
//     busy     - conversion in progress (converter -> producer)
//     done     - one-cycle pulse when bcd_out/overflow update
//     bcd_out  - packed BCD, digit3..digit0 in [15:12]..[3:0]
//     overflow - captured value exceeded the saturation limit
//
//   Modports: master = producer side, slave = converter side.
interface bin2bcd_seq_if #(
  parameter int BIN_W = 14
);
  logic             start;
  logic [BIN_W-1:0] bin_in;
  logic             busy;
  logic             done;
  logic [15:0]      bcd_out;
  logic             overflow;

  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  bcd_out,
    input  overflow
  );

  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output bcd_out,
    output overflow
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//   Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble),
//   one input bit per clock. Feeds the 4-digit seven-segment multiplexer, so
//   the result register only changes on a completed conversion.
//
//   Ports:
//     clk_i-style scalars kept plain:
//       clk    - system clock
//       rst_n  - asynchronous active-low reset
//     bus (bin2bcd_seq_if.slave):
//       start, bin_in  - conversion request, sampled only while idle
//       busy, done     - progress flag and one-cycle completion pulse
//       bcd_out        - packed BCD result, most significant digit in [15:12]
//       overflow       - bin_in was above MAX_VAL when captured
//
//   Parameters:
//     BIN_W   - binary input width (4..14)
//     MAX_VAL - saturation limit; larger inputs are clamped before conversion
//
//   Optional build macro:
//     BIN2BCD_BLANK_LEADING_ZERO_EN - replace leading zero digits (digit3 down
//     to digit1) with 4'hF so the downstream decoder blanks them.
module bin2bcd_seq #(
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = 9999
) (
  input logic         clk,
  input logic         rst_n,
  bin2bcd_seq_if.slave bus
);

  localparam logic [31:0]      MaxValU  = 32'(MAX_VAL);
  localparam logic [BIN_W-1:0] MaxClamp = BIN_W'(MAX_VAL);
  localparam logic [3:0]       LastCnt  = 4'(BIN_W - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e           state_q;
  logic [BIN_W-1:0] shift_q;
  logic [15:0]      scratch_q;
  logic [15:0]      scratch_d;
  logic [15:0]      adjusted;
  logic [15:0]      result_d;
  logic [3:0]       count_q;
  logic             ovf_latch_q;
  logic             busy_q;
  logic             done_q;
  logic [15:0]      bcd_q;
  logic             overflow_q;
  logic             over_limit;

  // Saturation compare, only meaningful at capture time.
  assign over_limit = (32'(bus.bin_in) > MaxValU);

  // Add 3 to every digit that is 5 or more, then shift the next binary bit
  // in. Each digit stays 4 bits: a digit <= 9 after the shift cannot carry.
  always_comb begin
    adjusted = scratch_q;
    for (int i = 0; i < 4; i++) begin
      if (scratch_q[i*4 +: 4] >= 4'd5) begin
        adjusted[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
      end
    end
    scratch_d = {adjusted[14:0], shift_q[BIN_W-1]};
  end

`ifdef BIN2BCD_BLANK_LEADING_ZERO_EN
  // Leading zeros from digit3 downward become 4'hF; digit0 always shows.
  always_comb begin
    logic leading;
    leading  = 1'b1;
    result_d = scratch_d;
    for (int i = 3; i >= 1; i--) begin
      if (leading && (scratch_d[i*4 +: 4] == 4'd0)) begin
        result_d[i*4 +: 4] = 4'hF;
      end else begin
        leading = 1'b0;
      end
    end
  end
`else
  always_comb begin
    result_d = scratch_d;
  end
`endif

  // Control FSM and all registered outputs. The result register is loaded
  // only on the final shift edge, so the display never sees partial values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      scratch_q   <= '0;
      count_q     <= '0;
      ovf_latch_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bcd_q       <= 16'h0000;
      overflow_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            shift_q     <= over_limit ? MaxClamp : bus.bin_in;
            scratch_q   <= '0;
            count_q     <= '0;
            ovf_latch_q <= over_limit;
            busy_q      <= 1'b1;
            state_q     <= SHIFT;
          end
        end
        SHIFT: begin
          scratch_q <= scratch_d;
          shift_q   <= {shift_q[BIN_W-2:0], 1'b0};
          count_q   <= count_q + 4'd1;
          if (count_q == LastCnt) begin
            bcd_q      <= result_d;
            overflow_q <= ovf_latch_q;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq
//   Directed-vector bench for bin2bcd_seq. Drives inputs on the falling edge
//   and samples outputs on the falling edge, away from the active rising edge.
//   Expected BCD values are hand-computed; the blanked variants are selected
//   when BIN2BCD_BLANK_LEADING_ZERO_EN is defined.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst_n;

  int vectorCount = 0;
  int missCount   = 0;

  // 100 MHz clock
  always #5 clk = ~clk;

  bin2bcd_seq_if #(.BIN_W(14)) bus ();

  bin2bcd_seq #(
    .BIN_W  (14),
    .MAX_VAL(9999)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // Chooses the expected value for the current build.
  function automatic logic [15:0] pick(input logic [15:0] raw, input logic [15:0] blanked);
`ifdef BIN2BCD_BLANK_LEADING_ZERO_EN
    return blanked;
`else
    return raw;
`endif
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // One-cycle start with the given value, optional extra start pulse while
  // busy, then a bounded wait for done and checks of timing and result.
  task automatic applyStimulus(input string tag, input logic [13:0] value,
                               input logic [15:0] expBcd, input logic expOvf,
                               input int lateStartAt, input logic [13:0] lateValue);
    logic [15:0] prevBcd;
    logic        prevOvf;
    int          waited;
    int          busyCount;
    bit          stable;
    bit          seen;
    bit          doneWithBusy;
    @(negedge clk);
    bus.bin_in = value;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.bin_in = ~value;
    prevBcd      = bus.bcd_out;
    prevOvf      = bus.overflow;
    waited       = 0;
    busyCount    = 0;
    stable       = 1'b1;
    seen         = 1'b0;
    doneWithBusy = 1'b0;
    while (!seen && waited < 40) begin
      if (bus.busy) busyCount++;
      if (bus.bcd_out !== prevBcd || bus.overflow !== prevOvf) stable = 1'b0;
      if (waited == lateStartAt) begin
        bus.bin_in = lateValue;
        bus.start  = 1'b1;
      end else begin
        bus.start  = 1'b0;
      end
      @(negedge clk);
      waited++;
      if (bus.done) seen = 1'b1;
      if (bus.done && bus.busy) doneWithBusy = 1'b1;
    end
    bus.start = 1'b0;
    checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
    checkOutput({tag, "_latency"}, 32'(waited), 32'd14);
    checkOutput({tag, "_busy_cycles"}, 32'(busyCount), 32'd14);
    checkOutput({tag, "_done_and_busy"}, 32'(doneWithBusy), 32'd0);
    checkOutput({tag, "_stable"}, 32'(stable), 32'd1);
    checkOutput({tag, "_bcd"}, 32'(bus.bcd_out), 32'(expBcd));
    checkOutput({tag, "_ovf"}, 32'(bus.overflow), 32'(expOvf));
    @(negedge clk);
    checkOutput({tag, "_done_clear"}, 32'(bus.done), 32'd0);
  endtask

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  waited;
    int  gap;
    int  extraDone;
    bit  doneInReset;

    // Reset state, both during reset and right after release.
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.bin_in = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_bcd", 32'(bus.bcd_out), 32'h0000);
    checkOutput("rst_ovf", 32'(bus.overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rel_busy", 32'(bus.busy), 32'd0);
    checkOutput("rel_bcd", 32'(bus.bcd_out), 32'h0000);

    // Main conversions and saturation boundaries.
    applyStimulus("v1234", 14'd1234, 16'h1234, 1'b0, -1, 14'd0);
    applyStimulus("v16383", 14'd16383, 16'h9999, 1'b1, -1, 14'd0);
    applyStimulus("v9999", 14'd9999, 16'h9999, 1'b0, -1, 14'd0);
    applyStimulus("v10000", 14'd10000, 16'h9999, 1'b1, -1, 14'd0);
    applyStimulus("v205", 14'd205, pick(16'h0205, 16'hF205), 1'b0, -1, 14'd0);
    applyStimulus("v0", 14'd0, pick(16'h0000, 16'hFFF0), 1'b0, -1, 14'd0);
    applyStimulus("v9", 14'd9, pick(16'h0009, 16'hFFF9), 1'b0, -1, 14'd0);
    applyStimulus("v1000", 14'd1000, 16'h1000, 1'b0, -1, 14'd0);

    // Start while busy is ignored: one done, result of the first value.
    applyStimulus("v42", 14'd42, pick(16'h0042, 16'hFF42), 1'b0, 5, 14'd7);
    extraDone = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) extraDone++;
    end
    checkOutput("v42_extra_done", 32'(extraDone), 32'd0);
    checkOutput("v42_idle_busy", 32'(bus.busy), 32'd0);

    // Start held high: back-to-back conversions every BIN_W+1 cycles.
    @(negedge clk);
    bus.bin_in = 14'd777;
    bus.start  = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.done && waited < 40);
    checkOutput("b2b_first_latency", 32'(waited), 32'd15);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!bus.done && gap < 40);
    bus.start = 1'b0;
    checkOutput("b2b_gap", 32'(gap), 32'd15);
    checkOutput("b2b_bcd", 32'(bus.bcd_out), 32'(pick(16'h0777, 16'hF777)));
    @(negedge clk);
    @(negedge clk);
    checkOutput("b2b_stopped", 32'(bus.busy), 32'd0);

    // Reset mid-conversion: leave an overflowed result in place first.
    applyStimulus("pre_rst", 14'd16383, 16'h9999, 1'b1, -1, 14'd0);
    @(negedge clk);
    bus.bin_in = 14'd5678;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    repeat (7) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_done", 32'(bus.done), 32'd0);
    checkOutput("abort_bcd", 32'(bus.bcd_out), 32'h0000);
    checkOutput("abort_ovf", 32'(bus.overflow), 32'd0);
    doneInReset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) doneInReset = 1'b1;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) doneInReset = 1'b1;
    end
    checkOutput("abort_no_done", 32'(doneInReset), 32'd0);
    checkOutput("abort_bcd_held", 32'(bus.bcd_out), 32'h0000);
    applyStimulus("v31", 14'd31, pick(16'h0031, 16'hFF31), 1'b0, -1, 14'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
